// File: rtl/burst_master_if.sv
// Bus-side channels of the 8-bit burst slave port (AR/R, AW/W/B).
// The master modport drives requests; the slave modport answers them.
interface burst_master_if;
  logic        ARVALID;
  logic        ARREADY;
  logic [15:0] AR_OUT;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;
  logic [8:0]  RDATA;
  logic        AWVALID;
  logic        AWREADY;
  logic [11:0] AW_OUT;
  logic        WVALID;
  logic        WREADY;
  logic        WLAST;
  logic [7:0]  WDATA;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  BRESP;

  modport master (
    output ARVALID, AR_OUT, RREADY,
    output AWVALID, AW_OUT,
    output WVALID, WLAST, WDATA, BREADY,
    input  ARREADY, RVALID, RLAST, RDATA,
    input  AWREADY, WREADY, BVALID, BRESP
  );

  modport slave (
    input  ARVALID, AR_OUT, RREADY,
    input  AWVALID, AW_OUT,
    input  WVALID, WLAST, WDATA, BREADY,
    output ARREADY, RVALID, RLAST, RDATA,
    output AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/burst_master.sv
// Burst bus initiator: one client command at a time, streams W/R beats.
// Optional BUS_TIMEOUT_EN adds a per-handshake wait limit (TIMEOUT_CYCLES).
module burst_master
`ifdef BUS_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [3:0] cmd_id,
  input  logic [7:0] cmd_addr,
  input  logic [3:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_err,
  output logic       rd_last,
  output logic       done,
  output logic       done_err,
  output logic [3:0] done_id,
  burst_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] id_q, id_d;
  logic [7:0] addr_q, addr_d;
  logic [3:0] len_q, len_d;
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       hs;
  logic       at_last;

  // len==0 wraps to 15, so a 16-beat burst ends on count 15
  assign at_last = (cnt_q == (len_q - 4'd1));

  assign bus.AR_OUT = {addr_q, len_q, id_q};
  assign bus.AW_OUT = {addr_q, id_q};

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] timer_q, timer_d;
  logic          waiting;
  logic          expired;

  assign waiting = (state_q == S_AR) || (state_q == S_R) ||
                   (state_q == S_AW) || (state_q == S_W) ||
                   (state_q == S_B);
  assign expired = waiting && !hs &&
                   (timer_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    hs          = 1'b0;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    rd_valid    = 1'b0;
    rd_data     = 8'h00;
    rd_err      = 1'b0;
    rd_last     = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    done_id     = 4'h0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b0;
    bus.WLAST   = 1'b0;
    bus.WDATA   = 8'h00;
    bus.BREADY  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          id_d    = cmd_id;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = 4'h0;
          err_d   = 1'b0;
          state_d = cmd_write ? S_AW : S_AR;
        end
      end
      S_AR: begin
        bus.ARVALID = 1'b1;
        if (bus.ARREADY) begin
          hs      = 1'b1;
          state_d = S_R;
        end
      end
      S_R: begin
        bus.RREADY = rd_ready;
        if (bus.RVALID && rd_ready) begin
          hs       = 1'b1;
          rd_valid = 1'b1;
          rd_data  = bus.RDATA[8:1];
          rd_err   = bus.RDATA[0];
          rd_last  = bus.RLAST || at_last;
          err_d    = err_q | bus.RDATA[0];
          cnt_d    = cnt_q + 4'd1;
          if (bus.RLAST || at_last) begin
            state_d = S_DONE;
          end
        end
      end
      S_AW: begin
        bus.AWVALID = 1'b1;
        if (bus.AWREADY) begin
          hs      = 1'b1;
          state_d = S_W;
        end
      end
      S_W: begin
        bus.WVALID = wr_valid;
        bus.WDATA  = wr_data;
        bus.WLAST  = at_last;
        wr_ready   = bus.WREADY;
        if (wr_valid && bus.WREADY) begin
          hs    = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (at_last) begin
            state_d = S_B;
          end
        end
      end
      S_B: begin
        bus.BREADY = 1'b1;
        if (bus.BVALID) begin
          hs      = 1'b1;
          err_d   = err_q | bus.BRESP[4] |
                    (bus.BRESP[3:0] != id_q);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        done_id  = id_q;
        done_err = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef BUS_TIMEOUT_EN
    // valids/readies fall because DONE drives none of them
    if (expired) begin
      err_d   = 1'b1;
      state_d = S_DONE;
    end
    if (!waiting || hs || (state_d != state_q)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      id_q    <= 4'h0;
      addr_q  <= 8'h00;
      len_q   <= 4'h0;
      cnt_q   <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

endmodule
